keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles each column is driven; legal values are 4 and above.
REQ-002 Parameter DEBOUNCE_SCANS, default 4: consecutive identical full scans needed to accept a press or a release; legal values are 2 and above.
REQ-003 Parameter REPEAT_SCANS, default 100: full scans between auto-repeat pulses; used only when KEYPAD_AUTOREPEAT_EN is defined.
REQ-004 The ports SHALL be:
- clk, input, 1: the only clock; every flop is on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- row, input, 4: keypad rows, active-low, externally pulled up, asynchronous to clk.
- clr, input, 1: synchronous clear of value.
- col, output, 4: column drive, active-low, exactly one column low at a time.
- key_code, output, 4: hex code of the last accepted key.
- key_valid, output, 1: one-cycle pulse for each accepted key.
- key_down, output, 1: high while a debounced key is held.
- value, output, 16: the last four accepted digits, oldest digit in the MSBs; this port feeds the 7-segment display value input.

Function
REQ-005 Each row bit SHALL pass through a 2-flop synchronizer before use.
REQ-006 A divider SHALL produce a tick every SCAN_DIV cycles; col_idx SHALL advance 0,1,2,3,0 on each tick; col = ~(4'b0001 << col_idx).
REQ-007 Synchronized rows SHALL be sampled in the tick cycle, the last cycle of the column period, for the current col_idx.
REQ-008 A full scan SHALL end on the tick where col_idx is 3. Scan result = hit plus code of the first low row found, searched lowest column first, then lowest row. Any further pressed keys are ignored.
REQ-009 Key map by row r and column c: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = 0 F E D.
REQ-010 FSM states are IDLE, DEBOUNCE, PRESSED, RELEASE. Transitions are evaluated only at scan end:
- IDLE: on hit, store the code as candidate, set cnt=1, go to DEBOUNCE.
- DEBOUNCE: on hit with the same code, cnt++; when cnt reaches DEBOUNCE_SCANS, go to PRESSED and accept the key. On a miss or a different code, go to IDLE.
- PRESSED: on a miss, set cnt=1 and go to RELEASE. On any hit (same or different key), stay.
- RELEASE: on a miss, cnt++; when cnt reaches DEBOUNCE_SCANS, go to IDLE. On any hit, go to PRESSED with no new key_valid.
REQ-011 Accepting a key SHALL, in the clk cycle after the deciding scan-end tick: pulse key_valid for exactly one cycle, load key_code, and shift value <= {value[11:0], code}.
REQ-012 key_down SHALL be high exactly while the state is PRESSED or RELEASE.
REQ-013 If clr and a key acceptance occur in the same cycle, value SHALL become {12'h000, code}.
REQ-014 A key held indefinitely SHALL produce exactly one key_valid, unless KEYPAD_AUTOREPEAT_EN is defined.

Reset
REQ-015 On reset assertion, immediately and independent of clk: col=4'b1110, col_idx=0, divider=0, synchronizers=4'hF, state=IDLE, cnt=0, key_code=0, key_valid=0, key_down=0, value=16'h0000.
REQ-016 Reset asserted mid-debounce or while a key is held SHALL discard the press. After release of reset, a still-held key needs a full DEBOUNCE_SCANS before it is accepted.

Configuration
REQ-017 Macro KEYPAD_AUTOREPEAT_EN:
- Defined: in PRESSED, a repeat counter counts scans with the same key hit. Each time it reaches REPEAT_SCANS it re-accepts the key (key_valid pulse and value shift) and restarts. The counter clears on entering PRESSED.
- Undefined: the repeat counter logic is absent and REQ-014 applies strictly.

Structure
REQ-018 Package keypad_pkg SHALL hold the FSM state enum, the 4x4 key-map constant, and the default parameter values.
REQ-019 Sub-module keypad_debounce_fsm SHALL contain REQ-010 to REQ-014 and REQ-017. The top level holds the synchronizer, the divider/column scan, and the scan-result encoder.

Verification
Bench settings: SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=5; a row model drives a row low while col matches the held key.
REQ-020 Hold key 5 (r1,c1) for 10 scans -> exactly one key_valid, key_code=4'h5, value=16'h0005, key_down high until 3 scans after release.
REQ-021 Enter 1, 2, A, F with clean presses and releases -> value=16'h12AF; a fifth key 7 -> value=16'h2AF7.
REQ-022 Key 9 bounces (held 2 scans, released 1, held 5) -> one key_valid with key_code=4'h9, accepted 3 scans after the final hold begins.
REQ-023 Hold 3 and E together -> key_code=4'h3 only. Then clr together with a new key 8 acceptance -> value=16'h0008.
REQ-024 Assert rst mid-DEBOUNCE while key C is held -> all outputs at REQ-015 values asynchronously; no key_valid until 3 full scans after rst deasserts.
REQ-025 With KEYPAD_AUTOREPEAT_EN, hold key 0 for 20 scans -> key_valid at acceptance, then every 5 scans: 4 pulses, value=16'h0000, key_code=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   - kp_state_e : debounce FSM states
//   - KEY_MAP    : hex code per (row, column), indexed KEY_MAP[row][col]
//   - *_DEF      : default parameter values
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  localparam int SCAN_DIV_DEF       = 50000;
  localparam int DEBOUNCE_SCANS_DEF = 4;
  localparam int REPEAT_SCANS_DEF   = 100;

  // One 16-bit word per row (row 3 in the MSBs), one nibble per column
  // (column 0 in the LSBs of each word).
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: 0 F E D
  localparam logic [3:0][3:0][3:0] KEY_MAP = {16'hDEF0, 16'hC987, 16'hB654, 16'hA321};

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Debounce / key-acceptance FSM. Evaluates once per full keypad scan.
// Ports:
//   clk, rst        clock, async active-high reset
//   clr_i           synchronous clear of value_o
//   scan_end_i      one-cycle strobe on the tick that ends a full scan
//   hit_i, code_i   scan result (valid with scan_end_i)
//   key_code_o      code of the last accepted key
//   key_valid_o     one-cycle pulse per accepted key
//   key_down_o      high while a debounced key is held
//   value_o         last four accepted digits, oldest in the MSBs
// Optional build macro KEYPAD_AUTOREPEAT_EN: re-accepts a held key every
// REPEAT_SCANS scans while in PRESSED.
module keypad_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF
`ifdef KEYPAD_AUTOREPEAT_EN
 ,parameter int REPEAT_SCANS   = REPEAT_SCANS_DEF
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        scan_end_i,
  input  logic        hit_i,
  input  logic [3:0]  code_i,
  output logic [3:0]  key_code_o,
  output logic        key_valid_o,
  output logic        key_down_o,
  output logic [15:0] value_o
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  kp_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]     cand_q, cand_d;
  logic [3:0]     key_code_q, key_code_d;
  logic           key_valid_q;
  logic [15:0]    value_q, value_d;
  logic           accept;
  logic           same_key;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0]  rep_q, rep_d, rep_inc;
  assign rep_inc = rep_q + 1'b1;
`endif

  assign cnt_inc  = cnt_q + 1'b1;
  assign same_key = hit_i && (code_i == cand_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    if (scan_end_i) begin
      unique case (state_q)
        IDLE: if (hit_i) begin
          cand_d  = code_i;
          cnt_d   = CW'(1);
          state_d = DEBOUNCE;
        end
        DEBOUNCE: if (same_key) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
            state_d = PRESSED;
            accept  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d   = '0;
`endif
          end
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
        PRESSED: if (!hit_i) begin
          cnt_d   = CW'(1);
          state_d = RELEASE;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (same_key) begin
          if (rep_inc == RW'(REPEAT_SCANS)) begin
            accept = 1'b1;
            rep_d  = '0;
          end else begin
            rep_d  = rep_inc;
          end
        end
`endif
        RELEASE: if (hit_i) begin
          // Bounce during release: back to held, no new acceptance.
          state_d = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_d   = '0;
`endif
        end else if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_inc;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output side: acceptance lands one cycle after the deciding tick.
  // clr in the same cycle as an acceptance leaves only the new digit.
  always_comb begin
    key_code_d = key_code_q;
    value_d    = value_q;
    if (clr_i) value_d = 16'h0000;
    if (accept) begin
      key_code_d = cand_q;
      value_d    = clr_i ? {12'h000, cand_q} : {value_q[11:0], cand_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      value_q     <= 16'h0000;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= accept;
      value_q     <= value_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_down_o  = (state_q == PRESSED) || (state_q == RELEASE);
  assign value_o     = value_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row synchronizer, column scan, scan-result
// encoder, and a debounce FSM producing accepted hex digits.
// Ports:
//   clk, rst   clock, async active-high reset
//   row[3:0]   active-low keypad rows (asynchronous to clk)
//   clr        synchronous clear of value
//   col[3:0]   active-low column drive, one column low at a time
//   key_code   code of last accepted key
//   key_valid  one-cycle pulse per accepted key
//   key_down   high while a debounced key is held
//   value      last four accepted digits, oldest in the MSBs
// Optional build macro KEYPAD_AUTOREPEAT_EN enables auto-repeat.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = SCAN_DIV_DEF,
  parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF,
  parameter int REPEAT_SCANS   = REPEAT_SCANS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [15:0] value
);

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("keypad_scanner: SCAN_DIV must be >= 4");
  end
  if (DEBOUNCE_SCANS < 2) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE_SCANS must be >= 2");
  end
  if (REPEAT_SCANS < 1) begin : g_bad_repeat
    $error("keypad_scanner: REPEAT_SCANS must be >= 1");
  end

  localparam int DW = $clog2(SCAN_DIV);

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] div_q;
  logic [1:0]    col_idx_q;
  logic          tick, scan_end;
  logic          col_hit;
  logic [3:0]    col_code;
  logic          acc_hit_q;
  logic [3:0]    acc_code_q;
  logic          scan_hit;
  logic [3:0]    scan_code;

  // Two-flop synchronizer; idle rows read high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
    end
  end

  assign tick     = (div_q == DW'(SCAN_DIV - 1));
  assign scan_end = tick && (col_idx_q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      col_idx_q <= 2'd0;
    end else if (tick) begin
      div_q     <= '0;
      col_idx_q <= col_idx_q + 2'd1;
    end else begin
      div_q     <= div_q + 1'b1;
    end
  end

  assign col = ~(4'b0001 << col_idx_q);

  // Lowest low row in the current column wins (loop runs high to low so
  // the last assignment is the lowest row).
  always_comb begin
    col_hit  = 1'b0;
    col_code = 4'h0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s2_q[r]) begin
        col_hit  = 1'b1;
        col_code = KEY_MAP[r][col_idx_q];
      end
    end
  end

  // Earlier columns take priority: keep the first hit seen in this scan.
  assign scan_hit  = acc_hit_q | col_hit;
  assign scan_code = acc_hit_q ? acc_code_q : col_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_hit_q  <= 1'b0;
      acc_code_q <= 4'h0;
    end else if (scan_end) begin
      acc_hit_q  <= 1'b0;
      acc_code_q <= 4'h0;
    end else if (tick && !acc_hit_q && col_hit) begin
      acc_hit_q  <= 1'b1;
      acc_code_q <= col_code;
    end
  end

  keypad_debounce_fsm #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
`ifdef KEYPAD_AUTOREPEAT_EN
   ,.REPEAT_SCANS   (REPEAT_SCANS)
`endif
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .scan_end_i  (scan_end),
    .hit_i       (scan_hit),
    .code_i      (scan_code),
    .key_code_o  (key_code),
    .key_valid_o (key_valid),
    .key_down_o  (key_down),
    .value_o     (value)
  );

endmodule
